// File: rtl/ddc_capture_core.sv
// Mixes (or bypasses) a real sample stream, integrate-and-dump decimates it under a phase accumulator, writes scaled {I,Q} words to a ring buffer.
// Latency: a dump-tagged sample accepted at edge k is written to the buffer at edge k+3; buffer read data follows rd_addr by one cycle.
// Backpressure: s_ready is high only while capturing (RUN); there is no downstream stall, so the pipeline never holds.
module ddc_capture_core #(
  parameter int DW    = 16,
  parameter int LW    = 16,
  parameter int OW    = 16,
  parameter int ACCW  = 40,
  parameter int AW    = 14,
  parameter int U_DLY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_mode,
  input  logic [31:0]       cfg_fw,
  input  logic [AW-1:0]     cfg_max_addr,
  input  logic [5:0]        cfg_shift,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic [LW-1:0]     lo_sin,
  input  logic [LW-1:0]     lo_cos,
  input  logic [AW-1:0]     rd_addr,
  output logic [2*OW-1:0]   rd_data,
  output logic [AW-1:0]     wr_addr,
  output logic [15:0]       wrap_cnt,
  output logic              sat_flag,
  output logic              busy
);

  localparam int PW = DW + LW;

  // U_DLY only matters for behavioural models with delayed assignments; this RTL updates with zero delay.
  if (U_DLY < 0) begin : g_u_dly_unused
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state_q;
  logic [1:0]        drain_cnt_q;
  logic              s_ready_q;
  logic              busy_q;

  // Configuration captured at arm time
  logic              cfg_mode_q, cfg_mode_d;
  logic [31:0]       cfg_fw_q, cfg_fw_d;
  logic [AW-1:0]     cfg_max_addr_q, cfg_max_addr_d;
  logic [5:0]        cfg_shift_q, cfg_shift_d;

  // Stage 0: accepted sample, LO and dump tag
  logic [31:0]       phase_q, phase_d;
  logic              in_vld_q, in_vld_d;
  logic              in_tag_q, in_tag_d;
  logic [DW-1:0]     in_s_q, in_s_d;
  logic [LW-1:0]     in_cos_q, in_cos_d;
  logic [LW-1:0]     in_sin_q, in_sin_d;

  // Stage 1: registered products
  logic              p_vld_q, p_vld_d;
  logic              p_tag_q, p_tag_d;
  logic [PW-1:0]     p_i_q, p_i_d;
  logic [PW-1:0]     p_q_q, p_q_d;

  // Stage 2: integrators and dump register
  logic [ACCW-1:0]   integ_i_q, integ_i_d;
  logic [ACCW-1:0]   integ_q_q, integ_q_d;
  logic              dump_vld_q, dump_vld_d;
  logic [ACCW-1:0]   dump_i_q, dump_i_d;
  logic [ACCW-1:0]   dump_q_q, dump_q_d;

  // Stage 3: buffer write bookkeeping
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [15:0]       wrap_cnt_q, wrap_cnt_d;
  logic              sat_flag_q, sat_flag_d;
  logic [2*OW-1:0]   rd_data_q;

  logic [2*OW-1:0]   mem [0:(1<<AW)-1];

  logic              accept;
  logic [32:0]       ph_sum;
  logic signed [PW-1:0] mix_i, mix_q;
  logic [PW-1:0]     byp_i;
  logic [ACCW-1:0]   sum_i, sum_q;
  logic [OW:0]       sc_i, sc_q;

  // Arithmetic shift by the captured amount, then clamp to the signed OW range; MSB of the result flags a clamp.
  function automatic logic [OW:0] scale_sat(input logic [ACCW-1:0] v, input logic [5:0] sh);
    logic signed [ACCW-1:0] s;
    s = $signed(v) >>> sh;
    if ((&s[ACCW-1:OW-1]) || !(|s[ACCW-1:OW-1]))
      scale_sat = {1'b0, s[OW-1:0]};
    else if (s[ACCW-1])
      scale_sat = {1'b1, 1'b1, {(OW-1){1'b0}}};
    else
      scale_sat = {1'b1, 1'b0, {(OW-1){1'b1}}};
  endfunction

  assign accept = s_valid & s_ready_q;
  assign ph_sum = {1'b0, phase_q} + {1'b0, cfg_fw_q};
  assign mix_i  = $signed(in_s_q) * $signed(in_cos_q);
  assign mix_q  = $signed(in_s_q) * $signed(in_sin_q);
  // Bypass routes the sample through at the same gain a full-scale LO would give.
  assign byp_i  = {in_s_q[DW-1], in_s_q, {(LW-1){1'b0}}};
  assign sum_i  = integ_i_q + {{(ACCW-PW){p_i_q[PW-1]}}, p_i_q};
  assign sum_q  = integ_q_q + {{(ACCW-PW){p_q_q[PW-1]}}, p_q_q};
  assign sc_i   = scale_sat(dump_i_q, cfg_shift_q);
  assign sc_q   = scale_sat(dump_q_q, cfg_shift_q);

  // Control FSM: IDLE -> ARM (one cycle) -> RUN -> DRAIN (three cycles) -> IDLE, with registered s_ready/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= 2'd0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_en) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          state_q   <= RUN;
          s_ready_q <= 1'b1;
        end
        RUN: begin
          if (!cfg_en) begin
            state_q     <= DRAIN;
            s_ready_q   <= 1'b0;
            drain_cnt_q <= 2'd2;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 2'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 2'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for the datapath: arm clears the run state, otherwise the four pipeline stages advance.
  always_comb begin
    cfg_mode_d     = cfg_mode_q;
    cfg_fw_d       = cfg_fw_q;
    cfg_max_addr_d = cfg_max_addr_q;
    cfg_shift_d    = cfg_shift_q;
    phase_d        = phase_q;
    in_vld_d       = 1'b0;
    in_tag_d       = in_tag_q;
    in_s_d         = in_s_q;
    in_cos_d       = in_cos_q;
    in_sin_d       = in_sin_q;
    p_vld_d        = 1'b0;
    p_tag_d        = p_tag_q;
    p_i_d          = p_i_q;
    p_q_d          = p_q_q;
    integ_i_d      = integ_i_q;
    integ_q_d      = integ_q_q;
    dump_vld_d     = 1'b0;
    dump_i_d       = dump_i_q;
    dump_q_d       = dump_q_q;
    ptr_d          = ptr_q;
    wr_addr_d      = wr_addr_q;
    wrap_cnt_d     = wrap_cnt_q;
    sat_flag_d     = sat_flag_q;

    if (state_q == ARM) begin
      cfg_mode_d     = cfg_mode;
      cfg_fw_d       = cfg_fw;
      cfg_max_addr_d = cfg_max_addr;
      cfg_shift_d    = cfg_shift;
      phase_d        = 32'd0;
      integ_i_d      = '0;
      integ_q_d      = '0;
      ptr_d          = '0;
      wrap_cnt_d     = 16'd0;
      sat_flag_d     = 1'b0;
    end else begin
      // Stage 0: advance the phase; the carry out marks the sample that closes a dump.
      in_vld_d = accept;
      if (accept) begin
        phase_d  = ph_sum[31:0];
        in_tag_d = ph_sum[32];
        in_s_d   = s_data;
        in_cos_d = lo_cos;
        in_sin_d = lo_sin;
      end
      // Stage 1: mix or bypass.
      p_vld_d = in_vld_q;
      if (in_vld_q) begin
        p_tag_d = in_tag_q;
        p_i_d   = cfg_mode_q ? byp_i : mix_i;
        p_q_d   = cfg_mode_q ? '0 : mix_q;
      end
      // Stage 2: integrate; a tagged sample is included in the dump and restarts the integrators.
      if (p_vld_q) begin
        if (p_tag_q) begin
          dump_vld_d = 1'b1;
          dump_i_d   = sum_i;
          dump_q_d   = sum_q;
          integ_i_d  = '0;
          integ_q_d  = '0;
        end else begin
          integ_i_d  = sum_i;
          integ_q_d  = sum_q;
        end
      end
      // Stage 3: the buffer write itself happens in the memory block; track pointer, wraps and saturation here.
      if (dump_vld_q) begin
        wr_addr_d = ptr_q;
        if (ptr_q == cfg_max_addr_q) begin
          ptr_d      = '0;
          wrap_cnt_d = wrap_cnt_q + 16'd1;
        end else begin
          ptr_d      = ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        if (sc_i[OW] || sc_q[OW])
          sat_flag_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode_q     <= 1'b0;
      cfg_fw_q       <= 32'd0;
      cfg_max_addr_q <= '0;
      cfg_shift_q    <= 6'd0;
      phase_q        <= 32'd0;
      in_vld_q       <= 1'b0;
      in_tag_q       <= 1'b0;
      in_s_q         <= '0;
      in_cos_q       <= '0;
      in_sin_q       <= '0;
      p_vld_q        <= 1'b0;
      p_tag_q        <= 1'b0;
      p_i_q          <= '0;
      p_q_q          <= '0;
      integ_i_q      <= '0;
      integ_q_q      <= '0;
      dump_vld_q     <= 1'b0;
      dump_i_q       <= '0;
      dump_q_q       <= '0;
      ptr_q          <= '0;
      wr_addr_q      <= '0;
      wrap_cnt_q     <= 16'd0;
      sat_flag_q     <= 1'b0;
    end else begin
      cfg_mode_q     <= cfg_mode_d;
      cfg_fw_q       <= cfg_fw_d;
      cfg_max_addr_q <= cfg_max_addr_d;
      cfg_shift_q    <= cfg_shift_d;
      phase_q        <= phase_d;
      in_vld_q       <= in_vld_d;
      in_tag_q       <= in_tag_d;
      in_s_q         <= in_s_d;
      in_cos_q       <= in_cos_d;
      in_sin_q       <= in_sin_d;
      p_vld_q        <= p_vld_d;
      p_tag_q        <= p_tag_d;
      p_i_q          <= p_i_d;
      p_q_q          <= p_q_d;
      integ_i_q      <= integ_i_d;
      integ_q_q      <= integ_q_d;
      dump_vld_q     <= dump_vld_d;
      dump_i_q       <= dump_i_d;
      dump_q_q       <= dump_q_d;
      ptr_q          <= ptr_d;
      wr_addr_q      <= wr_addr_d;
      wrap_cnt_q     <= wrap_cnt_d;
      sat_flag_q     <= sat_flag_d;
    end
  end

  // Ring buffer storage; contents survive reset so earlier captures stay readable.
  always_ff @(posedge clk) begin
    if (dump_vld_q)
      mem[ptr_q] <= {sc_i[OW-1:0], sc_q[OW-1:0]};
  end

  // Registered read port; a same-cycle write to rd_addr is seen only on the following read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data_q <= '0;
    else
      rd_data_q <= mem[rd_addr];
  end

  assign s_ready  = s_ready_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign wr_addr  = wr_addr_q;
  assign wrap_cnt = wrap_cnt_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_ddc_capture_core.sv
// Directed and randomized captures of ddc_capture_core checked against a behavioural model of the buffer contents.
// Each capture: arm, feed samples (optionally with valid gaps), stop, then read back the surviving words.
// The model works on whole dumps: integer sums of products, phase wrap detection, shift and clamp.
module tb_ddc_capture_core;
  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_en = 1'b0;
  logic            cfg_mode = 1'b0;
  logic [31:0]     cfg_fw = 32'd0;
  logic [AW-1:0]   cfg_max_addr = '0;
  logic [5:0]      cfg_shift = 6'd0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [15:0]     s_data = 16'd0;
  logic [15:0]     lo_sin = 16'd0;
  logic [15:0]     lo_cos = 16'd0;
  logic [AW-1:0]   rd_addr = '0;
  logic [31:0]     rd_data;
  logic [AW-1:0]   wr_addr;
  logic [15:0]     wrap_cnt;
  logic            sat_flag;
  logic            busy;

  always #5 clk = ~clk;

  ddc_capture_core dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_fw(cfg_fw),
    .cfg_max_addr(cfg_max_addr), .cfg_shift(cfg_shift), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .lo_sin(lo_sin), .lo_cos(lo_cos), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wrap_cnt(wrap_cnt), .sat_flag(sat_flag), .busy(busy)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state
  bit          m_mode;
  longint      m_fw;
  longint      m_phase;
  int          m_shift;
  int          m_max;
  longint      m_acc_i;
  longint      m_acc_q;
  bit          m_sat;
  int          m_last_wr = 0;
  logic [31:0] m_words[$];

  // Pending stimulus
  logic [15:0] q_s[$];
  logic [15:0] q_c[$];
  logic [15:0] q_n[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_scale(input longint acc);
    longint v;
    v = acc >>> m_shift;
    if (v > 32767) begin
      m_sat = 1'b1;
      return 16'h7fff;
    end
    if (v < -32768) begin
      m_sat = 1'b1;
      return 16'h8000;
    end
    return v[15:0];
  endfunction

  task automatic model_accept(input logic [15:0] s, input logic [15:0] c, input logic [15:0] n);
    longint p;
    longint pi;
    longint pq;
    p = m_phase + m_fw;
    if (m_mode) begin
      pi = longint'($signed(s)) * 32768;
      pq = 0;
    end else begin
      pi = longint'($signed(s)) * longint'($signed(c));
      pq = longint'($signed(s)) * longint'($signed(n));
    end
    m_acc_i += pi;
    m_acc_q += pq;
    if (p >= 64'h1_0000_0000) begin
      m_phase = p - 64'h1_0000_0000;
      m_words.push_back({model_scale(m_acc_i), model_scale(m_acc_q)});
      m_acc_i = 0;
      m_acc_q = 0;
    end else begin
      m_phase = p;
    end
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] c, input logic [15:0] n);
    q_s.push_back(s);
    q_c.push_back(c);
    q_n.push_back(n);
  endtask

  task automatic arm(input bit mode, input logic [31:0] fw, input int maxa, input int sh);
    cfg_mode = mode;
    cfg_fw = fw;
    cfg_max_addr = AW'(maxa);
    cfg_shift = 6'(sh);
    cfg_en = 1'b1;
    m_mode = mode; m_fw = longint'(fw); m_max = maxa; m_shift = sh;
    m_phase = 0; m_acc_i = 0; m_acc_q = 0; m_sat = 1'b0;
    m_words.delete();
    @(posedge clk); #1;
    chk("arm_busy", 64'(busy), 64'(1'b1));
    @(posedge clk); #1;
    chk("run_ready", 64'(s_ready), 64'(1'b1));
    chk("arm_sat_clr", 64'(sat_flag), 64'(1'b0));
    chk("arm_wrap_clr", 64'(wrap_cnt), 64'(0));
    // Configuration must have been captured during ARM; later changes are ignored.
    cfg_mode = ~mode;
    cfg_fw = $urandom;
    cfg_shift = 6'($urandom);
    cfg_max_addr = AW'($urandom);
  endtask

  task automatic feed(input bit gaps);
    logic [15:0] d;
    for (int cyc = 0; cyc < 2000 && q_s.size() > 0; cyc++) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = q_s[0];
      lo_cos = q_c[0];
      lo_sin = q_n[0];
      if (s_valid && s_ready) begin
        model_accept(q_s[0], q_c[0], q_n[0]);
        d = q_s.pop_front();
        d = q_c.pop_front();
        d = q_n.pop_front();
      end
      @(posedge clk); #1;
    end
    chk("feed_done", 64'(q_s.size()), 64'(0));
    q_s.delete(); q_c.delete(); q_n.delete();
    s_valid = 1'b0;
  endtask

  task automatic stop_and_check();
    cfg_en = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data = 16'h1234;
    chk("drain_ready", 64'(s_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy", 64'(busy), 64'(1'b1));
      @(posedge clk); #1;
    end
    chk("idle_busy", 64'(busy), 64'(1'b0));
    chk("idle_ready", 64'(s_ready), 64'(1'b0));
    s_valid = 1'b0;
  endtask

  task automatic verify(input string tag);
    int n;
    int depth;
    int first;
    n = m_words.size();
    depth = m_max + 1;
    first = (n > depth) ? n - depth : 0;
    if (n - first > 6) first = n - 6;
    for (int j = first; j < n; j++) begin
      rd_addr = AW'(j % depth);
      @(posedge clk); #1;
      chk({tag, "_word"}, 64'(rd_data), 64'(m_words[j]));
    end
    if (n > 0) m_last_wr = (n - 1) % depth;
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_last_wr));
    chk({tag, "_wrap"}, 64'(wrap_cnt), 64'(n / depth));
    chk({tag, "_sat"}, 64'(sat_flag), 64'(m_sat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fw;
    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wrap", 64'(wrap_cnt), 64'(0));
    chk("rst_sat", 64'(sat_flag), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Bypass, four samples per dump; second write lands exactly 3 cycles after the 8th accept.
    arm(1'b1, 32'h4000_0000, 100, 15);
    for (int i = 0; i < 8; i++) push(16'd100, 16'd0, 16'd0);
    feed(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_wr_before", 64'(wr_addr), 64'(0));
    @(posedge clk); #1;
    chk("t1_wr_at_k3", 64'(wr_addr), 64'(1));
    stop_and_check();
    verify("t1");

    // Complex mix with quadrature LO, gaps on valid.
    arm(1'b0, 32'h8000_0000, 100, 14);
    for (int i = 0; i < 8; i++) push(16'd1000, 16'd16384, 16'hC000);
    feed(1'b1);
    stop_and_check();
    verify("t2");

    // Short ring: 20 samples, 10 dumps over 4 addresses.
    arm(1'b0, 32'h8000_0000, 3, 16);
    for (int i = 0; i < 20; i++) push(16'($urandom), 16'($urandom), 16'($urandom));
    feed(1'b1);
    stop_and_check();
    verify("t3");

    // Positive and negative full-scale saturation.
    arm(1'b1, 32'h8000_0000, 100, 0);
    push(16'h7fff, 16'd0, 16'd0); push(16'h7fff, 16'd0, 16'd0);
    push(16'h8000, 16'd0, 16'd0); push(16'h8000, 16'd0, 16'd0);
    feed(1'b0);
    stop_and_check();
    verify("t4");

    // Stop before the first dump completes: no write, sticky flag cleared by re-arm.
    arm(1'b0, 32'h4000_0000, 100, 10);
    for (int i = 0; i < 3; i++) push(16'($urandom), 16'($urandom), 16'($urandom));
    feed(1'b0);
    stop_and_check();
    verify("t5");

    // Randomized captures.
    for (int t = 0; t < 5; t++) begin
      fw = 32'h1000_0000 + ($urandom % 32'hF000_0000);
      arm(1'($urandom_range(0, 1)), fw, $urandom_range(2, 9), $urandom_range(0, 24));
      for (int i = 0; i < 24; i++) push(16'($urandom), 16'($urandom), 16'($urandom));
      feed(1'b1);
      stop_and_check();
      verify("rnd");
    end

    // Reset mid-run: outputs clear at once, buffer contents survive.
    arm(1'b0, 32'h8000_0000, 100, 12);
    for (int i = 0; i < 6; i++) push(16'($urandom), 16'($urandom), 16'($urandom));
    feed(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rd_addr = AW'(1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("mid_rst_wrap", 64'(wrap_cnt), 64'(0));
    chk("mid_rst_sat", 64'(sat_flag), 64'(0));
    chk("mid_rst_rd_data", 64'(rd_data), 64'(0));
    cfg_en = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_word1", 64'(rd_data), 64'(m_words[1]));
    m_last_wr = 0;

    // Re-arm after reset starts again at address 0.
    arm(1'b1, 32'h6000_0000, 5, 14);
    for (int i = 0; i < 16; i++) push(16'($urandom), 16'($urandom), 16'($urandom));
    feed(1'b1);
    stop_and_check();
    verify("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
